// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Op-code and state encodings shared by the ALU top level and
//                its iterative multiply/divide engine.
//                Optional build macro: ALU_SIGNED_MULDIV_EN (MULS/DIVS).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_MULU  = 4'b0000;
   localparam logic [3:0] OP_DIVU  = 4'b0001;
   localparam logic [3:0] OP_SHIFT = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0011;
   localparam logic [3:0] OP_MULS  = 4'b0100;
   localparam logic [3:0] OP_DIVS  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0111;
   localparam logic [3:0] OP_ASL   = 4'b1011;
   localparam logic [3:0] OP_OR    = 4'b1100;
   localparam logic [3:0] OP_AND   = 4'b1101;
   localparam logic [3:0] OP_XOR   = 4'b1110;
   localparam logic [3:0] OP_A     = 4'b1111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef ALU_SIGNED_MULDIV_EN
   localparam logic c_SIGNED_EN = 1'b1;
`else
   localparam logic c_SIGNED_EN = 1'b0;
`endif

   // Signed op codes only count as multi-cycle ops when the feature is built in.
   function automatic logic f_is_signed(input logic [3:0] op);
      return c_SIGNED_EN && ((op == OP_MULS) || (op == OP_DIVS));
   endfunction

   function automatic logic f_is_muldiv(input logic [3:0] op);
      return (op == OP_MULU) || (op == OP_DIVU) || f_is_signed(op);
   endfunction

   function automatic logic f_is_div(input logic [3:0] op);
      return (op == OP_DIVU) || (c_SIGNED_EN && (op == OP_DIVS));
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Iterative unsigned engine: one shift-add multiply step or one
//                restoring-divide step per step pulse. qout/rout present the
//                post-step low/high halves so the final step can be captured
//                by the caller on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
   parameter int DW = 16,
   parameter int SW = $clog2(DW)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic          div,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          last,
   output logic [DW-1:0] qout,
   output logic [DW-1:0] rout
);

   localparam logic [SW-1:0] c_LAST = SW'(DW-1);

   logic [DW-1:0] r_b;
   logic [DW-1:0] r_hi;
   logic [DW-1:0] r_lo;
   logic [SW-1:0] r_cnt;

   logic [DW:0]   w_sum;
   logic [DW:0]   w_sh;
   logic [DW-1:0] w_sub;
   logic          w_ge;
   logic [DW-1:0] w_hi_nxt;
   logic [DW-1:0] w_lo_nxt;

   // Multiply: hi accumulates, multiplier bits shift out of lo as product bits shift in.
   assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(DW+1){1'b0}});
   // Divide: partial remainder in hi, dividend bits shift out of lo, quotient bits in.
   assign w_sh  = {r_hi, r_lo[DW-1]};
   assign w_ge  = (w_sh >= {1'b0, r_b});
   assign w_sub = w_sh[DW-1:0] - r_b;

   // Next-state of the partial registers for the selected algorithm.
   always_comb begin
      w_hi_nxt = w_sum[DW:1];
      w_lo_nxt = {w_sum[0], r_lo[DW-1:1]};
      if (div) begin
         w_hi_nxt = w_ge ? w_sub : w_sh[DW-1:0];
         w_lo_nxt = {r_lo[DW-2:0], w_ge};
      end
   end

   assign last = step && (r_cnt == c_LAST);
   assign qout = w_lo_nxt;
   assign rout = w_hi_nxt;

   // Operand latch, partial registers and iteration counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_cnt <= '0;
      end else if (load) begin
         r_b   <= b;
         r_hi  <= '0;
         r_lo  <= a;
         r_cnt <= '0;
      end else if (step) begin
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : CPU ALU with single-cycle add/sub/logic/shift-rotate and an
//                iterative multiply/divide behind a start/busy/done handshake,
//                frozen entirely while RDY is low.
//                Optional build macro: ALU_SIGNED_MULDIV_EN (MULS/DIVS).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int DW = 16,
   parameter int SW = $clog2(DW)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          RDY,
   input  logic          start,
   input  logic [3:0]    op,
   input  logic          right,
   input  logic          rotate,
   input  logic [DW-1:0] AI,
   input  logic [DW-1:0] BI,
   input  logic [SW-1:0] EI,
   input  logic          CI,
   output logic [DW-1:0] OUT,
   output logic [DW-1:0] OUTH,
   output logic          CO,
   output logic          V,
   output logic          Z,
   output logic          N,
   output logic          busy,
   output logic          done
);

   logic [1:0]    r_state;
   logic [DW-1:0] r_out;
   logic [DW-1:0] r_outh;
   logic          r_co;
   logic          r_v;
   logic          r_busy;
   logic          r_done;
   logic          r_div;

   // ---------------- single-cycle datapath ----------------
   logic [DW-1:0] w_addb;
   logic [DW:0]   w_sum;
   logic          w_add_v;
   logic [DW:0]   w_sl;
   logic signed [DW:0] w_sr_in;
   logic [DW:0]   w_sr;
   logic [DW:0]   w_rx;
   logic [SW:0]   w_kc;
   logic [DW:0]   w_rl;
   logic [DW:0]   w_rr;
   logic [DW-1:0] w_res;
   logic          w_co;
   logic          w_v;

   // Second adder operand: B, ~B for subtract, A for shift-left-by-add.
   always_comb begin
      case (op)
         OP_SUB:  w_addb = ~BI;
         OP_ASL:  w_addb = AI;
         default: w_addb = BI;
      endcase
   end

   assign w_sum   = {1'b0, AI} + {1'b0, w_addb} + {{DW{1'b0}}, CI};
   assign w_add_v = (AI[DW-1] == w_addb[DW-1]) && (w_sum[DW-1] != AI[DW-1]);

   // Plain shifts keep one extra bit so the last bit shifted out lands in bit DW / bit 0.
   assign w_sl    = {1'b0, AI} << EI;
   assign w_sr_in = {AI, 1'b0};
   assign w_sr    = w_sr_in >>> EI;
   // Rotates work on the (DW+1)-bit ring {carry, A}; a full-width shift yields 0 for k=0.
   assign w_rx    = {CI, AI};
   assign w_kc    = (SW+1)'(DW+1) - {1'b0, EI};
   assign w_rl    = (w_rx << EI) | (w_rx >> w_kc);
   assign w_rr    = (w_rx >> EI) | (w_rx << w_kc);

   // Single-cycle result and flags; reserved codes fall through to pass-A.
   always_comb begin
      w_res = AI;
      w_co  = CI;
      w_v   = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_ASL: begin
            w_res = w_sum[DW-1:0];
            w_co  = w_sum[DW];
            w_v   = w_add_v;
         end
         OP_OR:  w_res = AI | BI;
         OP_AND: w_res = AI & BI;
         OP_XOR: w_res = AI ^ BI;
         OP_SHIFT: begin
            if (rotate) begin
               {w_co, w_res} = right ? w_rr : w_rl;
            end else if (EI == '0) begin
               w_res = AI;
               w_co  = CI;
            end else if (right) begin
               w_res = w_sr[DW:1];
               w_co  = w_sr[0];
            end else begin
               w_res = w_sl[DW-1:0];
               w_co  = w_sl[DW];
            end
         end
         default: ;
      endcase
   end

   // ---------------- multi-cycle control ----------------
   logic          w_idle;
   logic          w_md;
   logic          w_dz;
   logic          w_load;
   logic          w_step;
   logic          w_last;
   logic [DW-1:0] w_q;
   logic [DW-1:0] w_r;
   logic [DW-1:0] w_eng_a;
   logic [DW-1:0] w_eng_b;
   logic [DW-1:0] w_fin_out;
   logic [DW-1:0] w_fin_outh;
   logic          w_fin_co;
   logic          w_fin_v;

   assign w_idle = (r_state != ST_RUN);
   assign w_md   = start && f_is_muldiv(op);
   assign w_dz   = f_is_div(op) && (BI == '0);
   assign w_load = RDY && w_idle && w_md && !w_dz;
   assign w_step = RDY && (r_state == ST_RUN);

`ifdef ALU_SIGNED_MULDIV_EN
   logic            r_sgn;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            w_sgn;
   logic [2*DW-1:0] w_prod;
   logic [2*DW-1:0] w_prod_c;
   logic [DW-1:0]   w_q_c;
   logic [DW-1:0]   w_r_c;

   // Signed ops feed operand magnitudes into the unsigned engine.
   assign w_sgn   = f_is_signed(op);
   assign w_eng_a = (w_sgn && AI[DW-1]) ? (~AI + 1'b1) : AI;
   assign w_eng_b = (w_sgn && BI[DW-1]) ? (~BI + 1'b1) : BI;

   assign w_prod   = {w_r, w_q};
   assign w_prod_c = r_neg_q ? (~w_prod + 1'b1) : w_prod;
   assign w_q_c    = r_neg_q ? (~w_q + 1'b1) : w_q;
   assign w_r_c    = r_neg_r ? (~w_r + 1'b1) : w_r;

   // Final result with sign correction; a positive quotient with the top bit set is min/-1.
   always_comb begin
      w_fin_out  = w_q;
      w_fin_outh = w_r;
      w_fin_co   = r_div ? 1'b0 : (|w_r);
      w_fin_v    = 1'b0;
      if (r_sgn) begin
         if (r_div) begin
            w_fin_out  = w_q_c;
            w_fin_outh = w_r_c;
            w_fin_co   = 1'b0;
            w_fin_v    = !r_neg_q && w_q[DW-1];
         end else begin
            w_fin_out  = w_prod_c[DW-1:0];
            w_fin_outh = w_prod_c[2*DW-1:DW];
            w_fin_co   = (w_prod_c[2*DW-1:DW] != {DW{w_prod_c[DW-1]}});
         end
      end
   end

   // Sign bookkeeping captured when an operation is launched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sgn   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_load) begin
         r_sgn   <= w_sgn;
         r_neg_q <= w_sgn && (AI[DW-1] ^ BI[DW-1]);
         r_neg_r <= w_sgn && AI[DW-1];
      end
   end
`else
   assign w_eng_a = AI;
   assign w_eng_b = BI;

   // Unsigned final result: carry flags a non-zero high product half.
   always_comb begin
      w_fin_out  = w_q;
      w_fin_outh = w_r;
      w_fin_co   = r_div ? 1'b0 : (|w_r);
      w_fin_v    = 1'b0;
   end
`endif

   alu_muldiv_iter #(
      .DW (DW),
      .SW (SW)
   ) u_iter (
      .clk   (clk),
      .reset (reset),
      .load  (w_load),
      .step  (w_step),
      .div   (r_div),
      .a     (w_eng_a),
      .b     (w_eng_b),
      .last  (w_last),
      .qout  (w_q),
      .rout  (w_r)
   );

   // State machine and output registers; nothing moves while RDY is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_outh  <= '0;
         r_co    <= 1'b0;
         r_v     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_div   <= 1'b0;
      end else if (RDY) begin
         if (r_state == ST_RUN) begin
            if (w_last) begin
               r_out   <= w_fin_out;
               r_outh  <= w_fin_outh;
               r_co    <= w_fin_co;
               r_v     <= w_fin_v;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
         end else begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
            if (w_md) begin
               r_div <= f_is_div(op);
               if (w_dz) begin
                  r_out   <= '1;
                  r_outh  <= AI;
                  r_co    <= 1'b0;
                  r_v     <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end else if (!f_is_muldiv(op)) begin
               // A mul/div code without start leaves the last result readable.
               r_out  <= w_res;
               r_outh <= '0;
               r_co   <= w_co;
               r_v    <= w_v;
            end
         end
      end
   end

   assign OUT  = r_out;
   assign OUTH = r_outh;
   assign CO   = r_co;
   assign V    = r_v;
   assign Z    = ~|r_out;
   assign N    = r_out[DW-1];
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Self-checking bench for alu_muldiv (DW=16): a table of
//                single-cycle vectors plus hand-written multi-cycle sequences.
//                Optional build macro: ALU_SIGNED_MULDIV_EN (MULS/DIVS).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic        RDY;
   logic        start;
   logic [3:0]  op;
   logic        right;
   logic        rotate;
   logic [15:0] AI;
   logic [15:0] BI;
   logic [3:0]  EI;
   logic        CI;
   logic [15:0] OUT;
   logic [15:0] OUTH;
   logic        CO;
   logic        V;
   logic        Z;
   logic        N;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [3:0]  op;
      logic        right;
      logic        rotate;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  e;
      logic        ci;
      logic [15:0] out;
      logic        co;
      logic        v;
      string       name;
   } vec_t;

   vec_t vecs[$];

   alu_muldiv #(.DW(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .RDY    (RDY),
      .start  (start),
      .op     (op),
      .right  (right),
      .rotate (rotate),
      .AI     (AI),
      .BI     (BI),
      .EI     (EI),
      .CI     (CI),
      .OUT    (OUT),
      .OUTH   (OUTH),
      .CO     (CO),
      .V      (V),
      .Z      (Z),
      .N      (N),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input logic [3:0] o, input logic r, input logic rot,
                          input logic [15:0] a, input logic [15:0] b, input logic [3:0] e,
                          input logic ci, input logic [15:0] eo, input logic eco,
                          input logic ev, input string nm);
      vec_t t;
      t.op = o; t.right = r; t.rotate = rot; t.a = a; t.b = b; t.e = e; t.ci = ci;
      t.out = eo; t.co = eco; t.v = ev; t.name = nm;
      vecs.push_back(t);
   endtask

   // Launch a mul/div op and wait for done; optional RDY stall and a stray start mid-run.
   task automatic do_md(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        input int stall_at, input int inject_at, input int exp_edges,
                        input logic [15:0] eo, input logic [15:0] eoh,
                        input logic eco, input logic ev, input string nm);
      int edges;
      op = o; AI = a; BI = b; start = 1'b1; RDY = 1'b1;
      tick();
      edges = 1;
      start = 1'b0;
      AI = ~a; BI = ~b;
      if (exp_edges > 1) chk({nm, "_busy1"}, {31'd0, busy}, 32'd1);
      while (done !== 1'b1 && edges < 60) begin
         if (edges == stall_at) RDY = 1'b0;
         if (edges == stall_at + 5) RDY = 1'b1;
         if (edges == inject_at) begin
            start = 1'b1; op = OP_DIVU; AI = 16'h0000; BI = 16'h0000;
         end
         tick();
         edges++;
         start = 1'b0; op = o;
         if (stall_at > 0 && edges == stall_at + 3)
            chk({nm, "_stall_busy"}, {30'd0, busy, done}, 32'd2);
      end
      chk({nm, "_edges"}, edges, exp_edges);
      chk({nm, "_out"},   {16'd0, OUT}, {16'd0, eo});
      chk({nm, "_outh"},  {16'd0, OUTH}, {16'd0, eoh});
      chk({nm, "_flags"}, {28'd0, CO, V, busy, Z}, {28'd0, eco, ev, 1'b0, (eo == 16'h0)});
   endtask

   initial begin
      reset = 1'b1; RDY = 1'b1; start = 1'b0; op = OP_A; right = 1'b0; rotate = 1'b0;
      AI = '0; BI = '0; EI = '0; CI = 1'b0;

      //                 op        r     rot   A        B        E      CI    OUT      CO    V
      add_vec(OP_ADD,   1'b0, 1'b0, 16'h7FFF, 16'h0001, 4'd0,  1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      add_vec(OP_ADD,   1'b0, 1'b0, 16'hFFFF, 16'h0001, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
      add_vec(OP_ADD,   1'b0, 1'b0, 16'h1234, 16'h1111, 4'd0,  1'b1, 16'h2346, 1'b0, 1'b0, "add_ci");
      add_vec(OP_SUB,   1'b0, 1'b0, 16'h0005, 16'h0003, 4'd0,  1'b1, 16'h0002, 1'b1, 1'b0, "sub");
      add_vec(OP_SUB,   1'b0, 1'b0, 16'h8000, 16'h0001, 4'd0,  1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
      add_vec(OP_ASL,   1'b0, 1'b0, 16'h4000, 16'h0000, 4'd0,  1'b0, 16'h8000, 1'b0, 1'b1, "asl_ovf");
      add_vec(OP_ASL,   1'b0, 1'b0, 16'hC001, 16'h0000, 4'd0,  1'b1, 16'h8003, 1'b1, 1'b0, "asl_ci");
      add_vec(OP_OR,    1'b0, 1'b0, 16'h00F0, 16'h0F00, 4'd0,  1'b1, 16'h0FF0, 1'b1, 1'b0, "or");
      add_vec(OP_AND,   1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 4'd0,  1'b0, 16'h3030, 1'b0, 1'b0, "and");
      add_vec(OP_XOR,   1'b0, 1'b0, 16'hFFFF, 16'h1234, 4'd0,  1'b1, 16'hEDCB, 1'b1, 1'b0, "xor");
      add_vec(OP_A,     1'b0, 1'b0, 16'h1357, 16'hFFFF, 4'd0,  1'b0, 16'h1357, 1'b0, 1'b0, "pass_a");
      add_vec(4'b1000,  1'b0, 1'b0, 16'hABCD, 16'h1111, 4'd0,  1'b1, 16'hABCD, 1'b1, 1'b0, "reserved");
      add_vec(OP_SHIFT, 1'b1, 1'b0, 16'h8001, 16'h0000, 4'd4,  1'b1, 16'hF800, 1'b0, 1'b0, "asr4");
      add_vec(OP_SHIFT, 1'b0, 1'b0, 16'h8001, 16'h0000, 4'd1,  1'b0, 16'h0002, 1'b1, 1'b0, "lsl1");
      add_vec(OP_SHIFT, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd0,  1'b1, 16'h1234, 1'b1, 1'b0, "lsl0");
      add_vec(OP_SHIFT, 1'b1, 1'b0, 16'h8000, 16'h0000, 4'd0,  1'b0, 16'h8000, 1'b0, 1'b0, "asr0");
      add_vec(OP_SHIFT, 1'b1, 1'b0, 16'h4000, 16'h0000, 4'd15, 1'b0, 16'h0000, 1'b1, 1'b0, "asr15");
      add_vec(OP_SHIFT, 1'b0, 1'b0, 16'h0001, 16'h0000, 4'd15, 1'b1, 16'h8000, 1'b0, 1'b0, "lsl15");
      add_vec(OP_SHIFT, 1'b0, 1'b1, 16'h8001, 16'h0000, 4'd1,  1'b0, 16'h0002, 1'b1, 1'b0, "rol1");
      add_vec(OP_SHIFT, 1'b1, 1'b1, 16'h8001, 16'h0000, 4'd1,  1'b0, 16'h4000, 1'b1, 1'b0, "ror1");
      add_vec(OP_SHIFT, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd4,  1'b1, 16'h1000, 1'b0, 1'b0, "ror4_ci");
      add_vec(OP_SHIFT, 1'b0, 1'b1, 16'h8000, 16'h0000, 4'd2,  1'b0, 16'h0001, 1'b0, 1'b0, "rol2_wrap");
      add_vec(OP_SHIFT, 1'b0, 1'b1, 16'h0001, 16'h0000, 4'd15, 1'b0, 16'h8000, 1'b0, 1'b0, "rol15");
`ifndef ALU_SIGNED_MULDIV_EN
      add_vec(OP_MULS,  1'b0, 1'b0, 16'h2468, 16'h0003, 4'd0,  1'b1, 16'h2468, 1'b1, 1'b0, "muls_reserved");
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out",   {16'd0, OUT},  32'd0);
      chk("rst_outh",  {16'd0, OUTH}, 32'd0);
      chk("rst_flags", {26'd0, CO, V, N, Z, busy, done}, 32'b000100);
      reset = 1'b0;

      // Single-cycle table
      foreach (vecs[i]) begin
         op = vecs[i].op; right = vecs[i].right; rotate = vecs[i].rotate;
         AI = vecs[i].a; BI = vecs[i].b; EI = vecs[i].e; CI = vecs[i].ci;
         start = 1'b1;
         tick();
         start = 1'b0;
         chk({vecs[i].name, "_out"},  {16'd0, OUT}, {16'd0, vecs[i].out});
         chk({vecs[i].name, "_flags"},
             {26'd0, OUTH == 16'h0, CO, V, Z, N, busy},
             {26'd0, 1'b1, vecs[i].co, vecs[i].v, vecs[i].out == 16'h0, vecs[i].out[15], 1'b0});
      end
      right = 1'b0; rotate = 1'b0; EI = '0; CI = 1'b0;

      // Multiply, then hold in DONE with no start
      do_md(OP_MULU, 16'h1234, 16'h0100, -1, -1, 17, 16'h3400, 16'h0012, 1'b1, 1'b0, "mulu");
      tick();
      chk("mulu_hold", {15'd0, done, OUT}, {15'd0, 1'b0, 16'h3400});

      // Same multiply with a 5-cycle RDY stall, then back-to-back divide from DONE
      do_md(OP_MULU, 16'h1234, 16'h0100, 8, -1, 22, 16'h3400, 16'h0012, 1'b1, 1'b0, "mulu_stall");
      do_md(OP_DIVU, 16'h1234, 16'h0010, -1, -1, 17, 16'h0123, 16'h0004, 1'b0, 1'b0, "divu");
      do_md(OP_DIVU, 16'h00AA, 16'h0000, -1, -1, 1,  16'hFFFF, 16'h00AA, 1'b0, 1'b1, "divu_zero");

      // Start during RUN must be ignored
      do_md(OP_MULU, 16'hFFFF, 16'hFFFF, -1, 5, 17, 16'h0001, 16'hFFFE, 1'b1, 1'b0, "mulu_inject");

      // Asynchronous reset in the middle of a multiply
      op = OP_MULU; AI = 16'h1234; BI = 16'h0100; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst", {13'd0, busy, done, Z, OUT}, {13'd0, 1'b0, 1'b0, 1'b1, 16'h0000});
      #2 reset = 1'b0;
      do_md(OP_DIVU, 16'hFFFF, 16'h0007, -1, -1, 17, 16'h2492, 16'h0001, 1'b0, 1'b0, "divu_after_rst");

`ifdef ALU_SIGNED_MULDIV_EN
      do_md(OP_MULS, 16'hFFFE, 16'h0003, -1, -1, 17, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0, "muls");
      do_md(OP_MULS, 16'h4000, 16'h0004, -1, -1, 17, 16'h0000, 16'h0001, 1'b1, 1'b0, "muls_big");
      do_md(OP_DIVS, 16'h8000, 16'hFFFF, -1, -1, 17, 16'h8000, 16'h0000, 1'b0, 1'b1, "divs_min");
      do_md(OP_DIVS, 16'h0007, 16'hFFFE, -1, -1, 17, 16'hFFFD, 16'h0001, 1'b0, 1'b0, "divs_pn");
      do_md(OP_DIVS, 16'hFFF9, 16'h0002, -1, -1, 17, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, "divs_np");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation CPU ALU for the 6502/65Org16 cores. Width is generic (DW).
- Keeps the single-cycle add/sub/logic ops and adds a clean variable barrel shift/rotate.
- Adds iterative multi-cycle unsigned multiply and divide, controlled by a start/busy/done handshake and stalled by RDY.
- Sits in the CPU datapath in place of the existing ALU. The sequencer waits on busy.

Parameters:
- DW, 16, data width (8 for 6502, 16 for 65Org16, any value ≥ 4)
- SW, $clog2(DW), shift-count width (derived; do not override)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- RDY  in  1  global stall; when low, all state holds (including the iteration counter)
- start  in  1  launches the MUL/DIV op on op; sampled in IDLE with RDY=1
- op  in  4  operation code (alu_pkg)
- right  in  1  shift direction for OP_SHIFT (1 = right)
- rotate  in  1  for OP_SHIFT: rotate through carry instead of shift
- AI  in  DW  operand A / dividend / multiplicand
- BI  in  DW  operand B / divisor / multiplier
- EI  in  SW  shift count 0..DW-1
- CI  in  1  carry in
- OUT  out  DW  result low (sum, logic, product low, quotient)
- OUTH  out  DW  product high / remainder; 0 for single-cycle ops
- CO  out  1  carry out
- V  out  1  overflow / divide-by-zero
- Z  out  1  ~|OUT (combinational from register)
- N  out  1  OUT[DW-1]
- busy  out  1  multi-cycle op in progress
- done  out  1  multi-cycle result valid

Behaviour:
- Reset values: OUT=0, OUTH=0, CO=0, V=0, N=0, Z=1, busy=0, done=0, state=IDLE, counter=0.
- Op codes:
  - 0011 A+B+CI
  - 0111 A+~B+CI
  - 1011 A+A+CI
  - 1100 OR
  - 1101 AND
  - 1110 XOR
  - 1111 pass A
  - 0010 SHIFT
  - 0000 MULU
  - 0001 DIVU
  - Others reserved: behave as pass A, CO=CI.
- Single-cycle ops: in IDLE or DONE with RDY=1 and no multi-cycle start, the result is registered every cycle (1-cycle latency). start is ignored for these ops.
- Add/sub flags: CO = carry out of bit DW-1. V = signed overflow at bit DW-1 (not bit 7). Logic ops: CO=CI, V=0.
- SHIFT, amount k=EI:
  - Left: zero fill.
  - Right: arithmetic, AI[DW-1] fill.
  - rotate=1: (DW+1)-bit rotate through CI.
  - CO = last bit shifted out. k=0: OUT=AI, CO=CI. V=0.
- State machine IDLE -> RUN -> DONE -> IDLE.
  - IDLE + RDY + start + op in {MULU, DIVU}: latch AI, BI; counter=0; go to RUN; busy=1.
  - DIVU with BI=0: go straight to DONE. OUT = all ones, OUTH = AI, V=1, CO=0.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV) step per RDY-high cycle.
  - After DW steps: write OUT/OUTH/flags, busy=0, done=1, go to DONE.
  - Latency is DW+1 RDY-high edges from the start edge to done high.
  - DONE: done stays high until the next RDY-high edge, then clears. A new start in DONE is accepted (back-to-back ops).
- MULU: {OUTH, OUT} = AI*BI. CO = |OUTH. V=0.
- DIVU: OUT = quotient, OUTH = remainder. CO=0. V=0 except on divide-by-zero.
- During RUN:
  - OUT/OUTH/flags hold their previous values.
  - start and op changes are ignored.
  - Operands are taken from the latch, so AI/BI may change freely.
- RDY low at any point: full freeze. done and busy also hold.
- Reset mid-operation: immediate return to reset values; a new start after reset deasserts works normally.

Optional Feature:
- ALU_SIGNED_MULDIV_EN
- Defined: op 0100 MULS and 0101 DIVS are enabled.
  - Implementation: operands are converted to magnitude, the unsigned engine runs, and the result is sign-corrected (quotient sign = sign A xor sign B; remainder takes the sign of A).
  - Latency is unchanged.
  - MULS: CO = 1 if OUTH is not the sign-extension of OUT.
  - DIVS: min / -1 → OUT = min, V=1.
- Undefined: 0100/0101 are reserved (pass A).

Decomposition:
- alu_pkg:
  - Op-code localparams (OP_ADD, OP_SUB, OP_ASL, OP_OR, OP_AND, OP_XOR, OP_A, OP_SHIFT, OP_MULU, OP_DIVU, OP_MULS, OP_DIVS).
  - State enum (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module, alu_muldiv_iter: the iterative MUL/DIV engine.
  - Holds the operand latch, partial registers and counter.
  - Signals: load, step (RDY & RUN), last, qout, rout.
- The top level holds the single-cycle datapath, the state machine and the output registers.

Test Plan (DW=16):
- ADD AI=7FFF BI=0001 CI=0 -> next cycle OUT=8000, N=1, V=1, CO=0, Z=0.
- SHIFT right=1 rotate=0 AI=8001 EI=4 -> OUT=F800, CO=0. Then right=0 AI=8001 EI=1 -> OUT=0002, CO=1.
- MULU start AI=1234 BI=0100 -> busy for 16 cycles, then done high at edge 17 with OUT=3400, OUTH=0012, CO=1. Repeat with RDY low for 5 cycles mid-run -> done at edge 22, identical result.
- DIVU AI=1234 BI=0010 -> OUT=0123, OUTH=0004, V=0 at edge 17. DIVU AI=00AA BI=0000 -> edge 1 done, OUT=FFFF, OUTH=00AA, V=1.
- Reset asserted at MULU step 8 -> busy=0, OUT=0, Z=1 immediately. A fresh DIVU afterwards completes correctly. A start during RUN is ignored (result unchanged).
- With ALU_SIGNED_MULDIV_EN: MULS FFFE*0003 -> OUT=FFFA, OUTH=FFFF, CO=0. DIVS 8000/FFFF -> OUT=8000, V=1.
